pipe_ctrl: RTL and testbench

Central pipeline controller for the 5-stage core.
- Drives the 6-bit stall vector and the flush strobe into every pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Converts per-stage stall requests and MEM-stage exception reports into a sequenced freeze, flush and redirect.
- Also tracks stall cycles for performance counting and runs a stall watchdog.

---
 rtl/pipe_ctrl_pkg.sv | 53 +++++
 rtl/pipe_ctrl_wdog.sv | 52 +++++
 rtl/pipe_ctrl.sv | 134 +++++++++++++
 tb/tb_pipe_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: stall patterns, exception
// codes, the default exception vector and FSM state encodings, plus the
// request-to-stall priority encoder used in both RUN and RECOVER.
package pipe_ctrl_pkg;

    // Per-bit hold values for the stall vector
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Stall patterns: a stage that stalls must also hold every older stage
    localparam logic [5:0] STALL_NONE = {6{NO_STOP}};
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_ALL  = {6{STOP}};

    // MEM-stage exception codes
    localparam logic [31:0] EXC_NONE         = 32'h0000_0000;
    localparam logic [31:0] EXC_INT          = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL      = 32'h0000_0008;
    localparam logic [31:0] EXC_INST_INVALID = 32'h0000_000a;
    localparam logic [31:0] EXC_OV           = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP         = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET         = 32'h0000_000e;

    localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_0020;

    // FSM state encodings
    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_FREEZE  = 2'd1;
    localparam logic [1:0] ST_FLUSH   = 2'd2;
    localparam logic [1:0] ST_RECOVER = 2'd3;

    // Highest-priority (oldest) requesting stage decides the stall pattern
    function automatic logic [5:0] req_stall(input logic req_if, input logic req_id,
                                             input logic req_ex, input logic req_mem);
        logic [5:0] pat;
        if (req_mem) begin
            pat = STALL_MEM;
        end else if (req_ex) begin
            pat = STALL_EX;
        end else if (req_id) begin
            pat = STALL_ID;
        end else if (req_if) begin
            pat = STALL_IF;
        end else begin
            pat = STALL_NONE;
        end
        return pat;
    endfunction

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// Stall watchdog: counts consecutive RUN cycles with a stall request and
// emits a registered one-cycle pulse when the run reaches WDOG_LIMIT cycles.
// Ports: clk, rst (async active-high), run_i (controller in RUN),
//        req_i (any stall request), timeout_o (one-cycle pulse).
module pipe_ctrl_wdog
    import pipe_ctrl_pkg::*;
#(
    parameter int WDOG_LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    input  logic req_i,
    output logic timeout_o
);

    localparam int            W    = $clog2(WDOG_LIMIT);
    localparam logic [W-1:0]  LAST = W'(WDOG_LIMIT - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         pulse_q, pulse_d;

    // Next count and pulse: any break in the stalled run restarts the count
    always_comb begin
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (run_i && req_i) begin
            if (cnt_q == LAST) begin
                cnt_d   = '0;
                pulse_d = 1'b1;
            end else begin
                cnt_d   = cnt_q + W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Watchdog state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign timeout_o = pulse_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller for the 5-stage core. Turns per-stage stall
// requests into a stall vector and sequences MEM-stage exceptions through
// FREEZE -> FLUSH -> RECOVER, producing a registered flush/redirect.
// Ports: clk, rst (async active-high); stallreq_from_{if,id,ex,mem};
//        excepttype_i (0 = none), cp0_epc_i (ERET target);
//        stall[5:0] (combinational hold vector), flush / new_pc (registered),
//        stall_cnt_o (stall-cycle counter), wdog_timeout_o (watchdog pulse).
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter int          WDOG_LIMIT = 1024,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_from_if,
    input  logic             stallreq_from_id,
    input  logic             stallreq_from_ex,
    input  logic             stallreq_from_mem,
    input  logic [31:0]      excepttype_i,
    input  logic [31:0]      cp0_epc_i,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             wdog_timeout_o
);

    logic [1:0]       state_q, state_d;
    logic [31:0]      target_q, target_d;
    logic             flush_q, flush_d;
    logic [31:0]      new_pc_q, new_pc_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic             any_req_s;
    logic             cnt_en_s;
    logic             run_s;
    logic [5:0]       stall_s;
    logic [5:0]       req_stall_s;

    assign any_req_s   = stallreq_from_if | stallreq_from_id |
                         stallreq_from_ex | stallreq_from_mem;
    assign req_stall_s = req_stall(stallreq_from_if, stallreq_from_id,
                                   stallreq_from_ex, stallreq_from_mem);
    assign run_s       = (state_q == ST_RUN);

    // Sequencer: stall vector, target latch and registered flush/redirect.
    // flush is set on the FREEZE->FLUSH edge so it is visible during FLUSH.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        flush_d  = 1'b0;
        new_pc_d = 32'h0000_0000;
        stall_s  = STALL_NONE;
        cnt_en_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                cnt_en_s = any_req_s;
                if (excepttype_i != EXC_NONE) begin
                    // Excepting and younger instructions are nullified in
                    // their stages, so nothing is held this cycle.
                    target_d = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
                    stall_s  = STALL_NONE;
                    state_d  = ST_FREEZE;
                end else begin
                    stall_s  = req_stall_s;
                end
            end
            ST_FREEZE: begin
                stall_s  = STALL_ALL;
                flush_d  = 1'b1;
                new_pc_d = target_q;
                state_d  = ST_FLUSH;
            end
            ST_FLUSH: begin
                stall_s  = STALL_NONE;
                state_d  = ST_RECOVER;
            end
            ST_RECOVER: begin
                // Exception input ignored: flushed registers may hold stale codes
                stall_s  = req_stall_s;
                cnt_en_s = any_req_s;
                state_d  = ST_RUN;
            end
            default: begin
                stall_s  = STALL_NONE;
                state_d  = ST_RUN;
            end
        endcase
    end

    // Stall-cycle counter; wraps naturally at 2^CNT_W
    always_comb begin
        if (cnt_en_s) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Controller state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            target_q    <= 32'h0000_0000;
            flush_q     <= 1'b0;
            new_pc_q    <= 32'h0000_0000;
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            flush_q     <= flush_d;
            new_pc_q    <= new_pc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    pipe_ctrl_wdog #(
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .run_i     (run_s),
        .req_i     (any_req_s),
        .timeout_o (wdog_timeout_o)
    );

    assign stall       = stall_s;
    assign flush       = flush_q;
    assign new_pc      = new_pc_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl. Inputs change on the falling edge;
// outputs are sampled 1 time unit later, so registered outputs reflect the
// previous rising edge and stall reflects the freshly driven requests.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_if, req_id, req_ex, req_mem;
    logic [31:0] exc;
    logic [31:0] epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cnt;
    logic        wdog;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp;
    int          n_mis;
    logic [31:0] exp_cnt;

    pipe_ctrl #(
        .EXC_VECTOR (32'h0000_0020),
        .WDOG_LIMIT (8),
        .CNT_W      (32)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stallreq_from_if  (req_if),
        .stallreq_from_id  (req_id),
        .stallreq_from_ex  (req_ex),
        .stallreq_from_mem (req_mem),
        .excepttype_i      (exc),
        .cp0_epc_i         (epc),
        .stall             (stall),
        .flush             (flush),
        .new_pc            (new_pc),
        .stall_cnt_o       (stall_cnt),
        .wdog_timeout_o    (wdog)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Overall time bound
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "time bound expired");
    end

    function automatic logic [31:0] observe(input int kind);
        logic [31:0] v;
        case (kind)
            0:       v = {26'h0, stall};
            1:       v = {31'h0, flush};
            2:       v = new_pc;
            3:       v = stall_cnt;
            4:       v = {31'h0, wdog};
            default: v = 32'hxxxx_xxxx;
        endcase
        return v;
    endfunction

    // Pop every pending expectation and compare against the DUT
    task automatic compare_sb();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.kind);
            n_cmp++;
            assert (obs === e.val) else begin
                n_mis++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    // Drive inputs at the falling edge; req = {mem, ex, id, if}
    task automatic drive(input logic [3:0] req, input logic [31:0] x, input logic [31:0] p);
        @(negedge clk);
        req_mem = req[3];
        req_ex  = req[2];
        req_id  = req[1];
        req_if  = req[0];
        exc     = x;
        epc     = p;
        #1;
    endtask

    task automatic chk(input string nm, input logic [5:0] e_stall, input logic e_flush,
                       input logic [31:0] e_pc, input logic e_wdog);
        sb.push_back('{{nm, ".stall"},  0, {26'h0, e_stall}});
        sb.push_back('{{nm, ".flush"},  1, {31'h0, e_flush}});
        sb.push_back('{{nm, ".new_pc"}, 2, e_pc});
        sb.push_back('{{nm, ".cnt"},    3, exp_cnt});
        sb.push_back('{{nm, ".wdog"},   4, {31'h0, e_wdog}});
        compare_sb();
    endtask

    initial begin
        n_cmp   = 0;
        n_mis   = 0;
        exp_cnt = 32'd0;
        rst     = 1'b1;
        req_if  = 1'b0;
        req_id  = 1'b0;
        req_ex  = 1'b0;
        req_mem = 1'b0;
        exc     = 32'h0;
        epc     = 32'h0;

        // Reset state
        drive(4'b0000, 32'h0, 32'h0);
        chk("reset", 6'b000000, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(4'b0000, 32'h0, 32'h0);
        chk("post_reset", 6'b000000, 1'b0, 32'h0, 1'b0);

        // 1. Request priority and stall counting
        drive(4'b1010, 32'h0, 32'h0);
        chk("prio_id_mem", 6'b011111, 1'b0, 32'h0, 1'b0);
        exp_cnt = exp_cnt + 32'd1;
        drive(4'b0010, 32'h0, 32'h0);
        chk("prio_id", 6'b000111, 1'b0, 32'h0, 1'b0);
        exp_cnt = exp_cnt + 32'd1;
        drive(4'b0000, 32'h0, 32'h0);
        chk("prio_none", 6'b000000, 1'b0, 32'h0, 1'b0);
        drive(4'b0001, 32'h0, 32'h0);
        chk("prio_if", 6'b000011, 1'b0, 32'h0, 1'b0);
        exp_cnt = exp_cnt + 32'd1;
        drive(4'b0100, 32'h0, 32'h0);
        chk("prio_ex", 6'b001111, 1'b0, 32'h0, 1'b0);
        exp_cnt = exp_cnt + 32'd1;

        // 2. Syscall
        drive(4'b0000, EXC_SYSCALL, 32'h0);
        chk("sys_detect", 6'b000000, 1'b0, 32'h0, 1'b0);
        drive(4'b0000, 32'h0, 32'h0);
        chk("sys_freeze", 6'b111111, 1'b0, 32'h0, 1'b0);
        drive(4'b0000, 32'h0, 32'h0);
        chk("sys_flush", 6'b000000, 1'b1, 32'h0000_0020, 1'b0);
        drive(4'b0000, 32'h0, 32'h0);
        chk("sys_recover", 6'b000000, 1'b0, 32'h0, 1'b0);
        drive(4'b0000, 32'h0, 32'h0);
        chk("sys_run", 6'b000000, 1'b0, 32'h0, 1'b0);

        // 3. ERET redirects to EPC; request honoured in RECOVER
        drive(4'b0000, EXC_ERET, 32'hBFC0_0100);
        chk("eret_detect", 6'b000000, 1'b0, 32'h0, 1'b0);
        drive(4'b0000, 32'h0, 32'h0);
        chk("eret_freeze", 6'b111111, 1'b0, 32'h0, 1'b0);
        drive(4'b0000, 32'h0, 32'h0);
        chk("eret_flush", 6'b000000, 1'b1, 32'hBFC0_0100, 1'b0);
        drive(4'b0010, 32'h0, 32'h0);
        chk("eret_recover", 6'b000111, 1'b0, 32'h0, 1'b0);
        exp_cnt = exp_cnt + 32'd1;
        drive(4'b0000, 32'h0, 32'h0);
        chk("eret_run", 6'b000000, 1'b0, 32'h0, 1'b0);

        // 4. Exception beats a stall request; stale codes do not retrigger
        drive(4'b0100, EXC_OV, 32'h0);
        chk("ov_detect", 6'b000000, 1'b0, 32'h0, 1'b0);
        exp_cnt = exp_cnt + 32'd1;
        drive(4'b0100, EXC_TRAP, 32'h0);
        chk("ov_freeze", 6'b111111, 1'b0, 32'h0, 1'b0);
        drive(4'b0100, 32'h0, 32'h0);
        chk("ov_flush", 6'b000000, 1'b1, 32'h0000_0020, 1'b0);
        drive(4'b0100, EXC_INST_INVALID, 32'h0);
        chk("ov_recover", 6'b001111, 1'b0, 32'h0, 1'b0);
        exp_cnt = exp_cnt + 32'd1;
        drive(4'b0000, 32'h0, 32'h0);
        chk("ov_run1", 6'b000000, 1'b0, 32'h0, 1'b0);
        drive(4'b0000, 32'h0, 32'h0);
        chk("ov_run2", 6'b000000, 1'b0, 32'h0, 1'b0);
        drive(4'b0000, 32'h0, 32'h0);
        chk("ov_run3", 6'b000000, 1'b0, 32'h0, 1'b0);

        // 5. Watchdog with limit 8: pulse follows the 8th and 16th stalled edge
        for (int k = 1; k <= 20; k++) begin
            drive(4'b1000, 32'h0, 32'h0);
            chk($sformatf("wdog_c%0d", k), 6'b011111, 1'b0, 32'h0,
                (k == 9) || (k == 17));
            exp_cnt = exp_cnt + 32'd1;
        end
        drive(4'b0000, 32'h0, 32'h0);
        chk("wdog_end", 6'b000000, 1'b0, 32'h0, 1'b0);

        // 6. Asynchronous reset while in FLUSH
        drive(4'b0000, EXC_INT, 32'h0);
        chk("rst_detect", 6'b000000, 1'b0, 32'h0, 1'b0);
        drive(4'b0000, 32'h0, 32'h0);
        chk("rst_freeze", 6'b111111, 1'b0, 32'h0, 1'b0);
        drive(4'b0000, 32'h0, 32'h0);
        chk("rst_flush", 6'b000000, 1'b1, 32'h0000_0020, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        exp_cnt = 32'd0;
        chk("rst_async", 6'b000000, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(4'b0100, 32'h0, 32'h0);
        chk("rst_run", 6'b001111, 1'b0, 32'h0, 1'b0);
        exp_cnt = exp_cnt + 32'd1;
        drive(4'b0000, 32'h0, 32'h0);
        chk("rst_after", 6'b000000, 1'b0, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
